// File: rtl/micro_sequencer_if.sv
// Microinstruction control fields, condition sources and sequencer outputs.
// The master drives the microinstruction side; the sequencer is the slave.
interface micro_sequencer_if #(
    parameter int STATE_W = 7
);
    logic [2:0]         next_sel;
    logic [1:0]         cond_sel;
    logic               cond_inv;
    logic [STATE_W-1:0] cr_addr;
    logic [STATE_W-1:0] enc_addr;
    logic               enc_valid;
    logic               mfc;
    logic               alu_zero;
    logic               alu_cond;
    logic [STATE_W-1:0] current_state;
    logic               illegal_op;
    logic               timeout;
    logic               stack_err;

    modport master (
        output next_sel, cond_sel, cond_inv, cr_addr, enc_addr, enc_valid,
        output mfc, alu_zero, alu_cond,
        input  current_state, illegal_op, timeout, stack_err
    );

    modport slave (
        input  next_sel, cond_sel, cond_inv, cr_addr, enc_addr, enc_valid,
        input  mfc, alu_zero, alu_cond,
        output current_state, illegal_op, timeout, stack_err
    );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: selects the next microstore address each cycle.
// Optional return stack for call/return is enabled by MICROSEQ_RETURN_STACK_EN.
module micro_sequencer #(
    parameter int                 STATE_W     = 7,
    parameter logic [STATE_W-1:0] FETCH_STATE = 7'd1,
    parameter int                 WAIT_LIMIT  = 15,
    parameter int                 STACK_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    micro_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        SEL_DISPATCH = 3'd0,
        SEL_FETCH    = 3'd1,
        SEL_BRANCH   = 3'd2,
        SEL_INCR     = 3'd3,
        SEL_JUMP     = 3'd4,
        SEL_CALL     = 3'd5,
        SEL_RETURN   = 3'd6,
        SEL_HOLD     = 3'd7
    } next_sel_e;

    logic [STATE_W-1:0] state_q, state_d;
    logic [3:0]         wait_q, wait_d;
    logic               ill_q, ill_d;
    logic               tmo_q, tmo_d;
    logic [STATE_W-1:0] inc_addr;
    logic               cond_src;
    logic               cond;
    next_sel_e          sel;

    assign sel      = next_sel_e'(bus.next_sel);
    assign inc_addr = state_q + STATE_W'(1);

    always_comb begin
        cond_src = 1'b1;
        case (bus.cond_sel)
            2'd0:    cond_src = bus.mfc;
            2'd1:    cond_src = bus.alu_zero;
            2'd2:    cond_src = bus.alu_cond;
            default: cond_src = 1'b1;
        endcase
        cond = cond_src ^ bus.cond_inv;
    end

`ifdef MICROSEQ_RETURN_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [STATE_W-1:0] stack_q [STACK_DEPTH];
    logic [SP_W-1:0]    sp_q, sp_d;
    logic [SP_W-1:0]    top_ptr;
    logic               err_q, err_d;
    logic               push_en;

    assign top_ptr = sp_q - SP_W'(1);
`endif

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        ill_d   = 1'b0;
        tmo_d   = 1'b0;
`ifdef MICROSEQ_RETURN_STACK_EN
        sp_d    = sp_q;
        err_d   = err_q;
        push_en = 1'b0;
`endif
        case (sel)
            SEL_DISPATCH: begin
                if (bus.enc_valid) begin
                    state_d = bus.enc_addr;
                end else begin
                    state_d = '0;
                    ill_d   = 1'b1;
                end
            end
            SEL_FETCH:  state_d = FETCH_STATE;
            SEL_BRANCH: state_d = cond ? bus.cr_addr : inc_addr;
            SEL_INCR:   state_d = inc_addr;
            SEL_JUMP:   state_d = bus.cr_addr;
`ifdef MICROSEQ_RETURN_STACK_EN
            SEL_CALL: begin
                state_d = bus.cr_addr;
                // A full stack still takes the jump; only the return address is lost.
                if (sp_q == SP_W'(STACK_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    push_en = 1'b1;
                    sp_d    = sp_q + SP_W'(1);
                end
            end
            SEL_RETURN: begin
                if (sp_q == '0) begin
                    state_d = '0;
                    err_d   = 1'b1;
                end else begin
                    state_d = stack_q[top_ptr[IDX_W-1:0]];
                    sp_d    = top_ptr;
                end
            end
`else
            SEL_CALL:   state_d = bus.cr_addr;
            SEL_RETURN: state_d = FETCH_STATE;
`endif
            SEL_HOLD: begin
                if (cond) begin
                    state_d = inc_addr;
                end else if (wait_q == 4'(WAIT_LIMIT - 1)) begin
                    // The counter would reach the limit this cycle: abandon the hold.
                    state_d = '0;
                    tmo_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= '0;
            wait_q  <= '0;
            ill_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ill_q   <= ill_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef MICROSEQ_RETURN_STACK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q  <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
            if (push_en) begin
                stack_q[sp_q[IDX_W-1:0]] <= inc_addr;
            end
        end
    end

    assign bus.stack_err = err_q;
`else
    assign bus.stack_err = 1'b0;
`endif

    assign bus.current_state = state_q;
    assign bus.illegal_op    = ill_q;
    assign bus.timeout       = tmo_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: queue-based reference model checked every
// cycle, plus literal expectations for the scenarios of interest.
module tb_micro_sequencer;
  localparam int         STATE_W     = 7;
  localparam logic [6:0] FETCH_STATE = 7'd1;
  localparam int         WAIT_LIMIT  = 15;
  localparam int         STACK_DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  micro_sequencer_if #(.STATE_W(STATE_W)) bus ();

  micro_sequencer #(
    .STATE_W(STATE_W),
    .FETCH_STATE(FETCH_STATE),
    .WAIT_LIMIT(WAIT_LIMIT),
    .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_state;
  bit m_ill;
  bit m_tmo;
  bit m_err;
  int m_wait;
  int m_stack[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit c;
    int nxt;
    case (bus.cond_sel)
      2'd0: c = bus.mfc;
      2'd1: c = bus.alu_zero;
      2'd2: c = bus.alu_cond;
      default: c = 1'b1;
    endcase
    c = c ^ bus.cond_inv;
    nxt = m_state;
    m_ill = 0;
    m_tmo = 0;
    if (bus.next_sel != 3'd7) m_wait = 0;
    case (bus.next_sel)
      3'd0: if (bus.enc_valid) nxt = bus.enc_addr; else begin nxt = 0; m_ill = 1; end
      3'd1: nxt = FETCH_STATE;
      3'd2: nxt = c ? int'(bus.cr_addr) : (m_state + 1) % 128;
      3'd3: nxt = (m_state + 1) % 128;
      3'd4: nxt = bus.cr_addr;
      3'd5: begin
        nxt = bus.cr_addr;
`ifdef MICROSEQ_RETURN_STACK_EN
        if (m_stack.size() < STACK_DEPTH) m_stack.push_back((m_state + 1) % 128);
        else m_err = 1;
`endif
      end
      3'd6: begin
`ifdef MICROSEQ_RETURN_STACK_EN
        if (m_stack.size() > 0) nxt = m_stack.pop_back();
        else begin nxt = 0; m_err = 1; end
`else
        nxt = FETCH_STATE;
`endif
      end
      default: begin
        if (c) begin
          nxt = (m_state + 1) % 128;
          m_wait = 0;
        end else if (m_wait + 1 >= WAIT_LIMIT) begin
          nxt = 0;
          m_tmo = 1;
          m_wait = 0;
        end else begin
          m_wait++;
        end
      end
    endcase
    m_state = nxt;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = 0;
      m_ill = 0;
      m_tmo = 0;
      m_err = 0;
      m_wait = 0;
      m_stack.delete();
    end else begin
      model_step();
    end
  end

  // Every-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    check("cyc_state", int'(bus.current_state), m_state);
    check("cyc_illegal_op", int'(bus.illegal_op), int'(m_ill));
    check("cyc_timeout", int'(bus.timeout), int'(m_tmo));
    check("cyc_stack_err", int'(bus.stack_err), int'(m_err));
  end

  task automatic step(input logic [2:0] ns, input logic [1:0] cs, input logic inv,
                      input logic [6:0] cr, input logic [6:0] enc, input logic ev,
                      input logic m, input logic az, input logic ac);
    @(negedge clk);
    bus.next_sel  = ns;
    bus.cond_sel  = cs;
    bus.cond_inv  = inv;
    bus.cr_addr   = cr;
    bus.enc_addr  = enc;
    bus.enc_valid = ev;
    bus.mfc       = m;
    bus.alu_zero  = az;
    bus.alu_cond  = ac;
    @(posedge clk);
    #2;
  endtask

  task automatic jump(input logic [6:0] addr);
    step(3'd4, 2'd3, 1'b0, addr, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("jump_target", int'(bus.current_state), int'(addr));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.next_sel  = 3'd3;
    bus.cond_sel  = 2'd3;
    bus.cond_inv  = 1'b0;
    bus.cr_addr   = '0;
    bus.enc_addr  = '0;
    bus.enc_valid = 1'b0;
    bus.mfc       = 1'b0;
    bus.alu_zero  = 1'b0;
    bus.alu_cond  = 1'b0;

    // Reset held with increment selected
    repeat (3) @(posedge clk);
    #2;
    check("reset_state", int'(bus.current_state), 0);
    check("reset_flags", int'({bus.illegal_op, bus.timeout, bus.stack_err}), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #2;
      check("incr_after_reset", int'(bus.current_state), i);
    end

    // Dispatch
    jump(7'd5);
    step(3'd0, 2'd3, 1'b0, 7'd0, 7'd17, 1'b1, 1'b0, 1'b0, 1'b0);
    check("dispatch_valid", int'(bus.current_state), 17);
    jump(7'd5);
    step(3'd0, 2'd3, 1'b0, 7'd0, 7'd17, 1'b0, 1'b0, 1'b0, 1'b0);
    check("dispatch_invalid_state", int'(bus.current_state), 0);
    check("illegal_op_pulse", int'(bus.illegal_op), 1);
    step(3'd3, 2'd3, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("illegal_op_clears", int'(bus.illegal_op), 0);
    check("incr_from_zero", int'(bus.current_state), 1);

    // Hold on mfc: 3 waits then release
    jump(7'd9);
    for (int i = 0; i < 3; i++) begin
      step(3'd7, 2'd0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("hold_wait", int'(bus.current_state), 9);
    end
    step(3'd7, 2'd0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("hold_release", int'(bus.current_state), 10);

    // Hold timeout
    jump(7'd9);
    for (int i = 1; i < WAIT_LIMIT; i++) begin
      step(3'd7, 2'd0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("hold_before_limit", int'(bus.current_state), 9);
      check("no_early_timeout", int'(bus.timeout), 0);
    end
    step(3'd7, 2'd0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("timeout_state", int'(bus.current_state), 0);
    check("timeout_pulse", int'(bus.timeout), 1);
    step(3'd3, 2'd3, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("timeout_clears", int'(bus.timeout), 0);

    // Conditional branch on inverted alu_zero
    jump(7'd12);
    step(3'd2, 2'd1, 1'b1, 7'd20, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("branch_not_taken", int'(bus.current_state), 13);
    jump(7'd12);
    step(3'd2, 2'd1, 1'b0, 7'd20, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("branch_taken", int'(bus.current_state), 20);
    jump(7'd12);
    step(3'd2, 2'd2, 1'b0, 7'd33, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("branch_alu_cond", int'(bus.current_state), 33);

    // Wrap and fetch
    jump(7'd127);
    step(3'd3, 2'd3, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("incr_wrap", int'(bus.current_state), 0);
    step(3'd1, 2'd3, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fetch", int'(bus.current_state), 1);

    // Reset asserted mid-hold acts without a clock edge
    jump(7'd9);
    step(3'd7, 2'd0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3'd7, 2'd0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_state", int'(bus.current_state), 0);
    @(negedge clk);
    bus.next_sel = 3'd3;
    reset = 1'b1;
    @(posedge clk);
    #2;
    check("after_mid_hold_reset", int'(bus.current_state), 1);

    // Call / return
    jump(7'd30);
    step(3'd5, 2'd3, 1'b0, 7'd40, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("call_target", int'(bus.current_state), 40);
    step(3'd6, 2'd3, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef MICROSEQ_RETURN_STACK_EN
    check("return_addr", int'(bus.current_state), 31);
    check("stack_ok", int'(bus.stack_err), 0);
    for (int i = 0; i < 5; i++) begin
      step(3'd5, 2'd3, 1'b0, 7'(50 + i), 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("nested_call", int'(bus.current_state), 50 + i);
      check("overflow_flag", int'(bus.stack_err), (i == 4) ? 1 : 0);
    end
    begin
      int exp_ret[4] = '{53, 52, 51, 32};
      for (int i = 0; i < 4; i++) begin
        step(3'd6, 2'd3, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("nested_return", int'(bus.current_state), exp_ret[i]);
      end
    end
    step(3'd6, 2'd3, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("underflow_state", int'(bus.current_state), 0);
    check("underflow_flag", int'(bus.stack_err), 1);
    step(3'd3, 2'd3, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("stack_err_sticky", int'(bus.stack_err), 1);
`else
    check("return_as_fetch", int'(bus.current_state), int'(FETCH_STATE));
    for (int i = 0; i < 6; i++) begin
      step(3'd5, 2'd3, 1'b0, 7'(50 + i), 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("call_as_jump", int'(bus.current_state), 50 + i);
    end
    step(3'd6, 2'd3, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("return_fetch_again", int'(bus.current_state), int'(FETCH_STATE));
    check("stack_err_tied", int'(bus.stack_err), 0);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL have parameter STATE_W, default 7, microstore address width.
REQ-002 SHALL have parameter FETCH_STATE, default 7'd1, first state of the instruction fetch microroutine.
REQ-003 SHALL have parameter WAIT_LIMIT, default 15, maximum number of hold cycles before timeout.
REQ-004 SHALL have parameter STACK_DEPTH, default 4, number of return-stack entries.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port next_sel, input, 3, next-state select field from the current microinstruction.
REQ-008 SHALL have port cond_sel, input, 2, condition select: 0 mfc, 1 alu_zero, 2 alu_cond, 3 constant 1.
REQ-009 SHALL have port cond_inv, input, 1, inverts the selected condition.
REQ-010 SHALL have port cr_addr, input, STATE_W, branch or jump target from the microinstruction.
REQ-011 SHALL have port enc_addr, input, STATE_W, opcode-decoded dispatch state.
REQ-012 SHALL have port enc_valid, input, 1, high when enc_addr holds a legal opcode.
REQ-013 SHALL have ports mfc, alu_zero and alu_cond, input, 1 each, the condition sources.
REQ-014 SHALL have port current_state, output, STATE_W, registered address that drives the microstore.
REQ-015 SHALL have port illegal_op, output, 1, one-cycle pulse on an invalid dispatch.
REQ-016 SHALL have port timeout, output, 1, one-cycle pulse when a hold times out.
REQ-017 SHALL have port stack_err, output, 1, sticky flag for return-stack overflow or underflow.

Function
REQ-018 SHALL compute cond as the selected source XOR cond_inv; the next state is derived combinationally from next_sel and cond and registered on the clock edge, giving one-cycle latency.
REQ-019 SHALL apply next_sel 0 (dispatch): next state is enc_addr if enc_valid=1; otherwise next state is 0 and illegal_op pulses.
REQ-020 SHALL apply next_sel 1 (fetch): next state is FETCH_STATE.
REQ-021 SHALL apply next_sel 2 (branch): next state is cr_addr if cond=1, otherwise current_state+1.
REQ-022 SHALL apply next_sel 3 (increment): next state is current_state+1, modulo 2^STATE_W, so 127 wraps to 0.
REQ-023 SHALL apply next_sel 4 (jump): next state is cr_addr unconditionally.
REQ-024 SHALL apply next_sel 5 (call): push current_state+1 onto the stack and go to cr_addr.
REQ-025 SHALL apply next_sel 6 (return): pop the top of the stack into current_state.
REQ-026 SHALL apply next_sel 7 (hold): keep current_state while cond=0 and increment the 4-bit wait counter; when cond=1, go to current_state+1 and clear the counter.
REQ-027 SHALL treat a hold whose counter reaches WAIT_LIMIT with cond still 0 as a timeout: next state 0, timeout pulses, counter cleared.
REQ-028 SHALL clear the wait counter whenever next_sel is not 7.
REQ-029 SHALL, on a call while the stack is full, still jump, discard the push and set stack_err.
REQ-030 SHALL, on a return while the stack is empty, go to state 0 and set stack_err.
REQ-031 SHALL clear stack_err only on reset.

Reset
REQ-032 SHALL, while reset=0, immediately force current_state=0, wait counter=0, stack empty, and illegal_op, timeout and stack_err all 0, regardless of clk.
REQ-033 SHALL apply a normal transition from state 0 on the first rising edge after reset deasserts; a reset asserted mid-hold or mid-subroutine discards all pending context.

Configuration
REQ-034 SHALL compile the return stack only when macro MICROSEQ_RETURN_STACK_EN is defined.
REQ-035 SHALL, when MICROSEQ_RETURN_STACK_EN is undefined, treat call as jump (no push), treat return as fetch (FETCH_STATE), and tie stack_err to 0.

Verification
REQ-036 SHALL cover: reset low with next_sel=3 -> current_state=0; release reset, 3 edges with next_sel=3 -> states 1,2,3.
REQ-037 SHALL cover: state 5, next_sel=0, enc_addr=7'd17, enc_valid=1 -> 17; repeat with enc_valid=0 -> state 0 and illegal_op high for exactly one cycle.
REQ-038 SHALL cover: state 9, next_sel=7, cond_sel=0, mfc low 3 cycles then high -> 9,9,9,10; mfc never high -> state 0 after WAIT_LIMIT cycles with a timeout pulse.
REQ-039 SHALL cover: state 12, next_sel=2, cond_sel=1, alu_zero=1, cond_inv=1, cr_addr=20 -> 13; with cond_inv=0 -> 20.
REQ-040 SHALL cover, with macro defined: state 30 calls cr_addr=40 -> 40; a return -> 31; 5 nested calls -> stack_err=1; a return on an empty stack -> state 0 with stack_err=1.
REQ-041 SHALL cover: state 127, next_sel=3 -> 0.
